mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 183 ++++++++++++++++++
 tb/tb_mem_access.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: MEM stage of the pipeline. Non-memory ops pass straight through
// to the MEM/WB register. Loads and stores run byte-serially over an 8-bit RAM
// port, with a pipeline stall requested until the access completes.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   mem_rd/wreg/wdata/pc   destination, write enable, ALU result, PC (EX/MEM)
//   mem_addr/reg2/aluop    effective address, store data, opcode (EX/MEM)
//   o_rd/wreg/wdata/pc     result to the MEM/WB register
//   stallreq_mem           stall request to the pipeline controller
//   ram_req/we/a/dout      byte request, write strobe, byte address, store byte
//   ram_din/ack            read byte, per-byte completion (same cycle as req)
//   misalign_err           only with MEM_MISALIGN_CHECK_EN: misaligned H/W op
//
// Optional feature macro: MEM_MISALIGN_CHECK_EN

`ifndef MEM_ACCESS_DEFINES
`define MEM_ACCESS_DEFINES
`define RegBus      32
`define RegAddrBus  5
`define AluOpBus    8
`define MemAddrBus  32
`define EXE_LB_OP   8'b1110_0000
`define EXE_LH_OP   8'b1110_0001
`define EXE_LW_OP   8'b1110_0011
`define EXE_LBU_OP  8'b1110_0100
`define EXE_LHU_OP  8'b1110_0101
`define EXE_SB_OP   8'b1110_1000
`define EXE_SH_OP   8'b1110_1001
`define EXE_SW_OP   8'b1110_1011
`endif

module mem_access (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [`RegAddrBus-1:0]   mem_rd,
  input  logic                     mem_wreg,
  input  logic [`RegBus-1:0]       mem_wdata,
  input  logic [`MemAddrBus-1:0]   mem_pc,
  input  logic [`MemAddrBus-1:0]   mem_addr,
  input  logic [`RegBus-1:0]       mem_reg2,
  input  logic [`AluOpBus-1:0]     mem_aluop,
  output logic [`RegAddrBus-1:0]   o_rd,
  output logic                     o_wreg,
  output logic [`RegBus-1:0]       o_wdata,
  output logic [`MemAddrBus-1:0]   o_pc,
  output logic                     stallreq_mem,
  output logic                     ram_req,
  output logic                     ram_we,
  output logic [`MemAddrBus-1:0]   ram_a,
  output logic [7:0]               ram_dout,
  input  logic [7:0]               ram_din,
  input  logic                     ram_ack
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic                     misalign_err
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [`RegBus-1:0] data_q, data_d;

  logic               is_load, is_store, is_half, is_word, is_mem;
  logic [1:0]         last_cnt;
  logic               misaligned;
  logic [`RegBus-1:0] st_shift;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    case (mem_aluop)
      `EXE_LB_OP, `EXE_LBU_OP: is_load = 1'b1;
      `EXE_LH_OP, `EXE_LHU_OP: begin is_load = 1'b1;  is_half = 1'b1; end
      `EXE_LW_OP:              begin is_load = 1'b1;  is_word = 1'b1; end
      `EXE_SB_OP:              is_store = 1'b1;
      `EXE_SH_OP:              begin is_store = 1'b1; is_half = 1'b1; end
      `EXE_SW_OP:              begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
    is_mem   = is_load | is_store;
    last_cnt = is_word ? 2'd3 : (is_half ? 2'd1 : 2'd0);
  end

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned   = (is_half && mem_addr[0]) || (is_word && (mem_addr[1:0] != 2'b00));
  assign misalign_err = rst && (state_q == IDLE) && is_mem && misaligned;
`else
  assign misaligned = 1'b0;
`endif

  // Little-endian store byte selection: byte cnt sits at bits [8*cnt +: 8].
  assign st_shift = mem_reg2 >> {cnt_q, 3'b000};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    o_rd         = mem_rd;
    o_pc         = mem_pc;
    o_wreg       = mem_wreg;
    o_wdata      = mem_wdata;
    stallreq_mem = 1'b0;
    ram_req      = 1'b0;
    ram_we       = 1'b0;
    ram_a        = '0;
    ram_dout     = 8'h00;

    case (state_q)
      IDLE: begin
        if (is_mem) begin
          o_wreg  = 1'b0;
          o_wdata = '0;
          // A rejected misaligned op completes in this cycle without a stall.
          if (!misaligned) begin
            stallreq_mem = 1'b1;
            state_d      = ACCESS;
            cnt_d        = 2'd0;
            data_d       = '0;
          end
        end
      end
      ACCESS: begin
        o_wreg       = 1'b0;
        o_wdata      = '0;
        stallreq_mem = 1'b1;
        ram_req      = 1'b1;
        ram_we       = is_store;
        ram_a        = mem_addr + {30'd0, cnt_q};
        ram_dout     = st_shift[7:0];
        if (ram_ack) begin
          if (is_load) data_d[{cnt_q, 3'b000} +: 8] = ram_din;
          if (cnt_q == last_cnt) state_d = DONE;
          else                   cnt_d   = cnt_q + 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        case (mem_aluop)
          `EXE_LB_OP:  o_wdata = {{24{data_q[7]}}, data_q[7:0]};
          `EXE_LBU_OP: o_wdata = {24'd0, data_q[7:0]};
          `EXE_LH_OP:  o_wdata = {{16{data_q[15]}}, data_q[15:0]};
          `EXE_LHU_OP: o_wdata = {16'd0, data_q[15:0]};
          `EXE_LW_OP:  o_wdata = data_q;
          default:     o_wdata = '0;
        endcase
        if (!is_load) o_wreg = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are forced low while reset is held; this also drops ram_req
    // immediately when reset hits mid-access.
    if (!rst) begin
      o_rd         = '0;
      o_pc         = '0;
      o_wreg       = 1'b0;
      o_wdata      = '0;
      stallreq_mem = 1'b0;
      ram_req      = 1'b0;
      ram_we       = 1'b0;
      ram_a        = '0;
      ram_dout     = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'b0010_0000;
  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;

  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [7:0]  d;
  } byte_t;

  typedef struct packed {
    logic [31:0] wdata;
    logic        wreg;
    logic [4:0]  rd;
    logic [31:0] pc;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic        mem_wreg = 1'b0;
  logic [31:0] mem_wdata = '0, mem_pc = '0, mem_addr = '0, mem_reg2 = '0;
  logic [7:0]  mem_aluop = OP_NOP;
  logic [4:0]  o_rd;
  logic        o_wreg;
  logic [31:0] o_wdata, o_pc;
  logic        stallreq_mem, ram_req, ram_we;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = 8'h00;
  logic        ram_ack = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  byte_t exp_q[$];
  byte_t obs_q[$];
  res_t  res_q[$];

  int    mem_delay = 0;
  bit    ack_force = 1'b0;
  int    stall_cnt;
  bit    timeout, hold_err, got_req, got_mis;
  res_t  got;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst),
    .mem_rd(mem_rd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_pc(mem_pc),
    .mem_addr(mem_addr), .mem_reg2(mem_reg2), .mem_aluop(mem_aluop),
    .o_rd(o_rd), .o_wreg(o_wreg), .o_wdata(o_wdata), .o_pc(o_pc),
    .stallreq_mem(stallreq_mem),
    .ram_req(ram_req), .ram_we(ram_we), .ram_a(ram_a), .ram_dout(ram_dout),
    .ram_din(ram_din), .ram_ack(ram_ack)
`ifdef MEM_MISALIGN_CHECK_EN
    , .misalign_err(misalign_err)
`endif
  );

  // Byte-wide RAM model: acks after mem_delay waiting cycles, same cycle as req.
  logic [7:0] mem [0:511];
  initial begin
    int wait_n;
    wait_n = 0;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[9'h100] = 8'h78; mem[9'h101] = 8'h56; mem[9'h102] = 8'h34; mem[9'h103] = 8'h12;
    mem[9'h104] = 8'hA1; mem[9'h105] = 8'hB2; mem[9'h106] = 8'hC3; mem[9'h107] = 8'hD4;
    mem[9'h007] = 8'h80;
    forever begin
      @(posedge clk);
      #2;
      if (ram_req) begin
        if (wait_n >= mem_delay) begin
          ram_ack = 1'b1;
          if (ram_we) mem[ram_a[8:0]] = ram_dout;
          else        ram_din = mem[ram_a[8:0]];
          wait_n = 0;
        end else begin
          ram_ack = 1'b0;
          ram_din = 8'hEE;
          wait_n++;
        end
      end else begin
        ram_ack = ack_force;
        ram_din = 8'hEE;
        wait_n  = 0;
      end
    end
  end

  // Drives one op for as long as the DUT stalls, records every acked byte and
  // the result seen in the first non-stalled cycle, then releases a NOP.
  task automatic issue_op(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] reg2, input logic [31:0] wdata,
                          input logic [4:0] rd, input logic wreg,
                          input logic [31:0] pc, input int delay);
    byte_t prev;
    bit    pend;
    @(posedge clk); #1;
    mem_aluop = op; mem_addr = addr; mem_reg2 = reg2; mem_wdata = wdata;
    mem_rd = rd; mem_wreg = wreg; mem_pc = pc; mem_delay = delay;
    stall_cnt = 0; timeout = 1'b1; hold_err = 1'b0; pend = 1'b0; got_mis = 1'b0;
    prev = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (stallreq_mem) stall_cnt++;
      if (ram_req) begin
        if (pend && (prev !== byte_t'{ram_we, ram_a, ram_dout})) hold_err = 1'b1;
        if (ram_ack) begin
          obs_q.push_back(byte_t'{ram_we, ram_a, ram_dout});
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          prev = byte_t'{ram_we, ram_a, ram_dout};
        end
      end
      if (!stallreq_mem) begin
        got     = res_t'{o_wdata, o_wreg, o_rd, o_pc};
        got_req = ram_req;
`ifdef MEM_MISALIGN_CHECK_EN
        got_mis = misalign_err;
`endif
        timeout = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
    mem_aluop = OP_NOP;
  endtask

  task automatic test_reset;
    mem_aluop = OP_ADD; mem_wdata = 32'hDEADBEEF; mem_wreg = 1'b1; mem_rd = 5'd3;
    mem_pc = 32'h44; ack_force = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({o_wdata, o_wreg, o_rd, o_pc} !== 70'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h, need 0", {o_wdata, o_wreg, o_rd, o_pc});
    end
    n_cmp++;
    if ({stallreq_mem, ram_req, ram_we, ram_a, ram_dout} !== 43'd0) begin
      n_bad++; $display("FAIL reset_ram: got %h, need 0", {stallreq_mem, ram_req, ram_we, ram_a, ram_dout});
    end
    ack_force = 1'b0;
    mem_aluop = OP_NOP;
    rst = 1'b1;
  endtask

  task automatic test_nonmem;
    ack_force = 1'b1;   // stray acks outside ACCESS must be ignored
    res_q.push_back(res_t'{32'h12345678, 1'b1, 5'd5, 32'h200});
    issue_op(OP_ADD, 32'h0, 32'h0, 32'h12345678, 5'd5, 1'b1, 32'h200, 0);
    ack_force = 1'b0;
    n_cmp++;
    if (got !== res_q.pop_front() || timeout) begin
      n_bad++; $display("FAIL add_passthru: got %h, need wdata 12345678 wreg 1 rd 5", got);
    end
    n_cmp++;
    if (stall_cnt != 0 || got_req !== 1'b0) begin
      n_bad++; $display("FAIL add_nostall: stall %0d req %0b, need 0/0", stall_cnt, got_req);
    end
  endtask

  task automatic test_lw;
    for (int k = 0; k < 4; k++) exp_q.push_back(byte_t'{1'b0, 32'h100 + k, 8'h00});
    res_q.push_back(res_t'{32'h12345678, 1'b1, 5'd7, 32'h300});
    issue_op(OP_LW, 32'h100, 32'h0, 32'hFFFF_0000, 5'd7, 1'b1, 32'h300, 0);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL lw_nbytes: got %0d, need %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      byte_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL lw_byte: got %h, need %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    n_cmp++;
    if (got !== res_q.pop_front() || timeout) begin
      n_bad++; $display("FAIL lw_result: got %h, need wdata 12345678", got);
    end
    n_cmp++;
    if (stall_cnt != 5) begin
      n_bad++; $display("FAIL lw_stall: got %0d cycles, need 5", stall_cnt);
    end
  endtask

  task automatic test_lb_lbu;
    res_q.push_back(res_t'{32'hFFFFFF80, 1'b1, 5'd9, 32'h310});
    issue_op(OP_LB, 32'h7, 32'h0, 32'h0, 5'd9, 1'b1, 32'h310, 0);
    n_cmp++;
    if (got !== res_q.pop_front() || timeout) begin
      n_bad++; $display("FAIL lb_sext: got %h, need wdata ffffff80", got);
    end
    n_cmp++;
    if (stall_cnt != 2) begin
      n_bad++; $display("FAIL lb_stall: got %0d, need 2", stall_cnt);
    end
    obs_q.delete();
    res_q.push_back(res_t'{32'h00000080, 1'b1, 5'd10, 32'h314});
    issue_op(OP_LBU, 32'h7, 32'h0, 32'h0, 5'd10, 1'b1, 32'h314, 1);
    obs_q.delete();
    n_cmp++;
    if (got !== res_q.pop_front() || timeout) begin
      n_bad++; $display("FAIL lbu_zext: got %h, need wdata 00000080", got);
    end
  endtask

  task automatic test_store_sh;
    exp_q.push_back(byte_t'{1'b1, 32'h20, 8'hDD});
    exp_q.push_back(byte_t'{1'b1, 32'h21, 8'hCC});
    res_q.push_back(res_t'{32'h0, 1'b0, 5'd11, 32'h320});
    issue_op(OP_SH, 32'h20, 32'hAABBCCDD, 32'h55555555, 5'd11, 1'b1, 32'h320, 3);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL sh_nbytes: got %0d, need %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      byte_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL sh_byte: got %h, need %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    n_cmp++;
    if (hold_err) begin n_bad++; $display("FAIL sh_hold: ram outputs moved while waiting, need stable"); end
    n_cmp++;
    if (got !== res_q.pop_front() || timeout) begin
      n_bad++; $display("FAIL sh_result: got %h, need wdata 0 wreg 0", got);
    end
    n_cmp++;
    if (stall_cnt != 9) begin n_bad++; $display("FAIL sh_stall: got %0d, need 9", stall_cnt); end
  endtask

  task automatic test_back_to_back;
    issue_op(OP_SW, 32'h40, 32'h8899AABB, 32'h0, 5'd1, 1'b0, 32'h330, 0);
    obs_q.delete();
    res_q.push_back(res_t'{32'hFFFF8899, 1'b1, 5'd12, 32'h334});
    issue_op(OP_LH, 32'h42, 32'h0, 32'h0, 5'd12, 1'b1, 32'h334, 0);
    obs_q.delete();
    n_cmp++;
    if (got !== res_q.pop_front() || timeout) begin
      n_bad++; $display("FAIL lh_after_sw: got %h, need wdata ffff8899", got);
    end
    res_q.push_back(res_t'{32'h0000AABB, 1'b1, 5'd13, 32'h338});
    issue_op(OP_LHU, 32'h40, 32'h0, 32'h0, 5'd13, 1'b1, 32'h338, 2);
    obs_q.delete();
    n_cmp++;
    if (got !== res_q.pop_front() || timeout) begin
      n_bad++; $display("FAIL lhu_after_sw: got %h, need wdata 0000aabb", got);
    end
  endtask

  task automatic test_reset_mid;
    int acks;
    bit seen;
    @(posedge clk); #1;
    mem_aluop = OP_LW; mem_addr = 32'h100; mem_reg2 = 32'h0; mem_rd = 5'd14;
    mem_wreg = 1'b1; mem_pc = 32'h340; mem_delay = 0;
    acks = 0; seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (ram_req && ram_ack) acks++;
      if (acks == 2) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL rstmid_acks: got %0d acks, need 2", acks); end
    #1 rst = 1'b0;
    mem_aluop = OP_NOP;
    #1;
    n_cmp++;
    if ({ram_req, stallreq_mem, ram_a, o_wdata, o_wreg} !== 67'd0) begin
      n_bad++; $display("FAIL rstmid_drop: got req %0b stall %0b a %h, need all 0", ram_req, stallreq_mem, ram_a);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ram_req !== 1'b0 || stallreq_mem !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_idle: got req %0b stall %0b, need 0/0", ram_req, stallreq_mem);
    end
    for (int k = 0; k < 4; k++) exp_q.push_back(byte_t'{1'b0, 32'h104 + k, 8'h00});
    res_q.push_back(res_t'{32'hD4C3B2A1, 1'b1, 5'd15, 32'h344});
    issue_op(OP_LW, 32'h104, 32'h0, 32'h0, 5'd15, 1'b1, 32'h344, 0);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      byte_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL rstmid_byte: got %h, need %h", o, e); end
    end
    n_cmp++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_bad++; $display("FAIL rstmid_nbytes: leftover exp %0d obs %0d, need 0/0", exp_q.size(), obs_q.size());
    end
    exp_q.delete(); obs_q.delete();
    n_cmp++;
    if (got !== res_q.pop_front() || timeout) begin
      n_bad++; $display("FAIL rstmid_result: got %h, need wdata d4c3b2a1", got);
    end
  endtask

`ifdef MEM_MISALIGN_CHECK_EN
  task automatic test_misalign;
    issue_op(OP_LW, 32'h102, 32'h0, 32'h0, 5'd16, 1'b1, 32'h350, 0);
    n_cmp++;
    if (got_mis !== 1'b1 || got_req !== 1'b0 || stall_cnt != 0 || got.wreg !== 1'b0) begin
      n_bad++; $display("FAIL misalign_lw: got err %0b req %0b stall %0d wreg %0b, need 1/0/0/0",
                        got_mis, got_req, stall_cnt, got.wreg);
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL misalign_noram: got %0d bytes, need 0", obs_q.size()); end
    obs_q.delete();
    @(negedge clk);
    n_cmp++;
    if (misalign_err !== 1'b0 || stallreq_mem !== 1'b0) begin
      n_bad++; $display("FAIL misalign_pulse: got err %0b stall %0b after release, need 0/0", misalign_err, stallreq_mem);
    end
    issue_op(OP_LH, 32'h21, 32'h0, 32'h0, 5'd17, 1'b1, 32'h354, 0);
    n_cmp++;
    if (got_mis !== 1'b1 || got_req !== 1'b0) begin
      n_bad++; $display("FAIL misalign_lh: got err %0b req %0b, need 1/0", got_mis, got_req);
    end
    obs_q.delete();
  endtask
`endif

  initial begin
    test_reset;
    test_nonmem;
    test_lw;
    test_lb_lbu;
    test_store_sh;
    test_back_to_back;
    test_reset_mid;
`ifdef MEM_MISALIGN_CHECK_EN
    test_misalign;
`endif
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, need completion");
    $fatal(1, "timeout");
  end

endmodule
